// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM and requester-id types for the main-memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select; round-robin with MEM_ARB_RR_EN, else data side wins
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    d_req,
  input  req_id_e last_grant,
  output req_id_e winner
);

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the port to whoever did not hold it last.
  always_comb begin
    winner = REQ_IF;
    if (if_req && d_req) begin
      winner = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
    end else if (d_req) begin
      winner = REQ_D;
    end
  end
`else
  logic unused_pick_inputs;
  assign unused_pick_inputs = if_req ^ (last_grant == REQ_D);

  always_comb begin
    winner = REQ_IF;
    if (d_req) begin
      winner = REQ_D;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester main-memory port arbiter (tie policy set by MEM_ARB_RR_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              grant_d
);

  arb_state_e state, state_nx;
  req_id_e    last_grant;
  req_id_e    winner;
  logic       any_req;

  assign any_req = if_req || d_req;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:              if (any_req) state_nx = (winner == REQ_D) ? GRANT_D : GRANT_IF;
      GRANT_IF, GRANT_D: if (mem_ack) state_nx = RESP;
      RESP:              state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  // grant_d is kept apart from last_grant so it can reset to 0 while the
  // round-robin pointer resets to favour fetch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      last_grant <= REQ_D;
      grant_d    <= 1'b0;
    end else if (state == IDLE) begin
      if (any_req) begin
        mem_req    <= 1'b1;
        last_grant <= winner;
        grant_d    <= (winner == REQ_D);
        if (winner == REQ_D) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
    end else if ((state == GRANT_IF || state == GRANT_D) && mem_ack) begin
      mem_req <= 1'b0;
      if (!mem_we) begin
        if (state == GRANT_D) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy   = (state != IDLE);
  assign if_ack = (state == RESP) && !grant_d;
  assign d_ack  = (state == RESP) && grant_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural memory/arbitration model
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        grant_d;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          spurious = 1'b0;
  logic        log_we = 1'b0;
  logic [31:0] log_addr = '0;
  logic [31:0] log_wdata = '0;

  always #5 CLK = ~CLK;

  mem_port_arbiter dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .grant_d   (grant_d)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Reference arbitration rule: 1 = data side wins.
  function automatic bit pick(input bit ir, input bit dr, input bit last_d);
    if (ir && dr) return RR ? !last_d : 1'b1;
    return dr;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit side_d, output int lat, output bit other_seen);
    lat = -1;
    other_seen = 1'b0;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(negedge CLK);
      if (side_d ? if_ack : d_ack) other_seen = 1'b1;
      if (side_d ? d_ack : if_ack) lat = i;
    end
  endtask

  // Memory responder: acks ack_delay cycles after mem_req is first seen.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      #2;
      mem_ack = 1'b0;
      if (spurious) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
          log_we    = mem_we;
          log_addr  = mem_addr;
          log_wdata = mem_wdata;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    int          lat;
    bit          oth;
    int          got;
    bit          exp_d;
    bit          model_last_d;
    bit          if_pend;
    bit          d_pend;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;

    repeat (3) @(negedge CLK);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_grant_d", grant_d, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Fetch read, memory acks 3 cycles after mem_req.
    ack_delay = 3; if_addr = 32'h100; if_req = 1'b1;
    @(negedge CLK);
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", mem_we, 0);
    check("t1_busy", busy, 1);
    check("t1_grant_d", grant_d, 0);
    wait_ack(1'b0, lat, oth);
    check("t1_latency", lat + 1, 5);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_no_d_ack", {oth, d_ack}, 0);
    if_req = 1'b0;
    @(negedge CLK);
    check("t1_ack_one_cycle", if_ack, 0);
    check("t1_idle", busy, 0);
    check("t1_mem_req_low", mem_req, 0);

    // Data write acked in the first mem_req cycle.
    ack_delay = 0; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_req = 1'b1;
    @(negedge CLK);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 32'h2000);
    check("t2_mem_wdata", mem_wdata, 32'h12345678);
    check("t2_grant_d", grant_d, 1);
    wait_ack(1'b1, lat, oth);
    check("t2_latency", lat + 1, 2);
    check("t2_d_rdata_kept", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge CLK);
    check("t2_ack_one_cycle", d_ack, 0);
    model_last_d = 1'b1;

    // Both held: the policy decides order; D dropped after the 4th ack.
    ack_delay = 1; if_addr = 32'h400; d_addr = 32'h500; if_req = 1'b1; d_req = 1'b1;
    if_pend = 1'b1; d_pend = 1'b1;
    for (int k = 0; k < 5; k++) begin
      got = -1;
      for (int c = 0; c < 40 && got < 0; c++) begin
        @(negedge CLK);
        if (if_ack) got = 0;
        else if (d_ack) got = 1;
      end
      exp_d = pick(if_pend, d_pend, model_last_d);
      check($sformatf("t3_grant%0d", k), got, {31'd0, exp_d});
      if (exp_d) check($sformatf("t3_d_rdata%0d", k), d_rdata, mem_val(32'h500));
      else       check($sformatf("t3_if_rdata%0d", k), if_rdata, mem_val(32'h400));
      model_last_d = exp_d;
      if (k == 3) begin d_req = 1'b0; d_pend = 1'b0; end
      if (k == 4) begin if_req = 1'b0; if_pend = 1'b0; end
    end
    @(negedge CLK);

    // D arrives during an IF transaction and waits for the IDLE cycle.
    ack_delay = 2; if_addr = 32'h600; if_req = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    d_we = 1'b0; d_addr = 32'h3000; d_req = 1'b1;
    wait_ack(1'b0, lat, oth);
    check("t4_if_ack_seen", lat > 0, 1);
    check("t4_if_rdata", if_rdata, mem_val(32'h600));
    check("t4_no_d_ack", {oth, d_ack}, 0);
    if_req = 1'b0;
    @(negedge CLK);
    check("t4_idle_gap_mem_req", mem_req, 0);
    check("t4_idle_gap_busy", busy, 0);
    @(negedge CLK);
    check("t4_d_mem_req", mem_req, 1);
    check("t4_d_grant", grant_d, 1);
    check("t4_d_mem_addr", mem_addr, 32'h3000);
    wait_ack(1'b1, lat, oth);
    check("t4_d_ack_seen", lat > 0, 1);
    check("t4_d_rdata", d_rdata, mem_val(32'h3000));
    check("t4_if_rdata_held", if_rdata, mem_val(32'h600));
    d_req = 1'b0;
    @(negedge CLK);

    // Reset in the middle of a data read.
    ack_delay = 20; d_addr = 32'h7000; d_req = 1'b1;
    repeat (3) @(negedge CLK);
    check("t5_in_grant_d", {busy, grant_d, mem_req}, 3'b111);
    RST_N = 1'b0;
    #1;
    check("t5_rst_mem_req", mem_req, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_acks", {if_ack, d_ack}, 0);
    check("t5_rst_grant_d", grant_d, 0);
    check("t5_rst_d_rdata", d_rdata, 0);
    @(negedge CLK);
    check("t5_rst_hold_acks", {if_ack, d_ack, mem_req}, 0);
    ack_delay = 1;
    RST_N = 1'b1;
    wait_ack(1'b1, lat, oth);
    check("t5_latency", lat, 3);
    check("t5_d_rdata", d_rdata, mem_val(32'h7000));
    d_req = 1'b0;
    model_last_d = 1'b1;
    exp_drd = mem_val(32'h7000);
    exp_ird = '0;
    @(negedge CLK);

    // Spurious mem_ack while idle.
    spurious = 1'b1;
    @(negedge CLK);
    spurious = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_acks", {if_ack, d_ack, mem_req}, 0);
    @(negedge CLK);
    check("t6_busy_after", busy, 0);
    check("t6_acks_after", {if_ack, d_ack, mem_req}, 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 24; t++) begin
      int   sel;
      int   served;
      int   n;
      bit   want_if;
      bit   want_d;
      bit   first_d;
      bit   dwe;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] dw;
      sel     = $urandom_range(0, 2);
      want_if = (sel != 1);
      want_d  = (sel != 0);
      ia      = $urandom & 32'h000F_FFFC;
      da      = $urandom & 32'h00F0_FFFC;
      dw      = $urandom;
      dwe     = 1'($urandom_range(0, 1));
      n       = int'(want_if) + int'(want_d);
      first_d = pick(want_if, want_d, model_last_d);
      served  = 0;
      @(negedge CLK);
      ack_delay = $urandom_range(0, 3);
      if_addr = ia; d_addr = da; d_wdata = dw; d_we = dwe;
      if_req = want_if; d_req = want_d;
      for (int c = 0; c < 60 && served < n; c++) begin
        @(negedge CLK);
        if (if_ack || d_ack) begin
          exp_d = (served == 0) ? first_d : !first_d;
          check("rnd_ack_side", {if_ack, d_ack}, exp_d ? 2'b01 : 2'b10);
          check("rnd_mem_addr", log_addr, exp_d ? da : ia);
          check("rnd_mem_we", log_we, exp_d ? dwe : 1'b0);
          if (exp_d && dwe) check("rnd_mem_wdata", log_wdata, dw);
          if (exp_d) begin
            if (!dwe) exp_drd = mem_val(da);
            d_req = 1'b0;
          end else begin
            exp_ird = mem_val(ia);
            if_req = 1'b0;
          end
          check("rnd_d_rdata", d_rdata, exp_drd);
          check("rnd_if_rdata", if_rdata, exp_ird);
          model_last_d = exp_d;
          served++;
        end
      end
      check("rnd_all_served", served, n);
      if_req = 1'b0; d_req = 1'b0;
    end

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
